// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths and FSM encoding for the SRAM port arbiter
package sram_arb_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: two-requester request/grant/done bus into the SRAM arbiter
interface sram_port_arbiter_if;
  import sram_arb_pkg::*;
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata
  );
endinterface

// File: rtl/sram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way picker, round-robin or port-0 fixed priority on ties
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic       sel_o,
  output logic       valid_o
);
  assign valid_o = |req_i;
  assign sel_o = &req_i ? (!fixed_i && !last_i) : req_i[1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: serialises two requesters onto one SRAM controller with registered strobes
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYC = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_port_arbiter_if.slave bus,
  output logic              sram_selec_o,
  output logic              sram_write_o,
  output logic              sram_read_o,
  output logic [ADDR_W-1:0] sram_addr_wr_o,
  output logic [DATA_W-1:0] sram_data_in_o,
  input  logic [DATA_W-1:0] sram_data_out_i,
  output logic              busy_o
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d, port_q, port_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d, done_q, done_d;
  logic              selec_q, selec_d, wr_q, wr_d, rd_q, rd_d;
  logic              pick_sel, pick_valid;

  rr_pick2 u_pick (
    .req_i   ({bus.req1, bus.req0}),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  // next state, operand latching and registered-output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: if (pick_valid) begin
        state_d         = ACCESS;
        cnt_d           = CNT_W'(ACCESS_CYC - 1);
        last_d          = pick_sel;
        port_d          = pick_sel;
        we_d            = pick_sel ? bus.we1 : bus.we0;
        addr_d          = pick_sel ? bus.addr1 : bus.addr0;
        wdata_d         = pick_sel ? bus.wdata1 : bus.wdata0;
        gnt_d[pick_sel] = 1'b1;
      end
      ACCESS: if (cnt_q == '0) begin
        state_d        = DONE;
        done_d[port_q] = 1'b1;
        rdata_d        = we_q ? rdata_q : sram_data_out_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    selec_d = state_d == ACCESS;
    wr_d    = selec_d && we_d;
    rd_d    = selec_d && !we_d;
  end

  // state and every output are registered; reset aborts any access silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      selec_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      selec_q <= selec_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.gnt0       = gnt_q[0];
  assign bus.gnt1       = gnt_q[1];
  assign bus.done0      = done_q[0];
  assign bus.done1      = done_q[1];
  assign bus.rdata      = rdata_q;
  assign sram_selec_o   = selec_q;
  assign sram_write_o   = wr_q;
  assign sram_read_o    = rd_q;
  assign sram_addr_wr_o = addr_q;
  assign sram_data_in_o = wdata_q;
  assign busy_o         = state_q != IDLE;
endmodule
